// File: rtl/mmio_console.sv
`default_nettype none
// ============================================================================
// Module      : mmio_console
// Description : Memory-mapped console on the data-memory bus. Stores to the
//               16-byte register window are buffered in a TX FIFO and drained
//               over a valid/ready byte stream. The block also holds a
//               free-running cycle counter and a sticky halt flag.
//               Optional macro MMIO_CONSOLE_PRINT_EN adds simulation-only
//               echo of drained bytes and ends the run after a halt.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_console #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FFF0,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_write_en,
  input  logic [31:0] mem_write_data,
  output logic        mmio_hit,
  output logic [31:0] mmio_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_CYCLE  = 2'd2;
  localparam logic [1:0] OFS_HALT   = 2'd3;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic [31:0]   cycle;

  logic [1:0]    offset;
  logic          bus_write;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          push_accept;
  logic [7:0]    count_ext;
  logic          unused_bits;

  assign mmio_hit    = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign offset      = mem_addr[3:2];
  assign bus_write   = mem_write_en && mmio_hit;
  assign push        = bus_write && (offset == OFS_TXDATA);
  assign full        = (count == DEPTH_CNT);
  assign empty       = (count == '0);
  assign tx_valid    = !empty;
  assign pop         = tx_valid && tx_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_accept = push && (!full || pop);
  assign count_ext   = 8'(count);
  // Gating on tx_valid keeps stale storage invisible after reset or drain.
  assign tx_data     = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign unused_bits = ^{mem_addr[1:0], mem_write_data[31:8]};

  // Byte storage; contents are never reset because they are masked when empty.
  always_ff @(posedge clk) begin
    if (push_accept) begin
      fifo_mem[wr_ptr] <= mem_write_data[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_accept, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end else if (bus_write && (offset == OFS_STATUS) && mem_write_data[2]) begin
        overflow <= 1'b0;
      end
    end
  end

  // Cycle counter runs until halted; halt is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle <= '0;
      halt  <= 1'b0;
    end else begin
      if (!halt) begin
        cycle <= cycle + 32'd1;
      end
      if (bus_write && (offset == OFS_HALT) && mem_write_data[0]) begin
        halt <= 1'b1;
      end
    end
  end

  // Zero-latency register read mux; returns 0 outside the window.
  always_comb begin
    mmio_rdata = '0;
    if (mmio_hit) begin
      case (offset)
        OFS_TXDATA: mmio_rdata = '0;
        OFS_STATUS: mmio_rdata = {16'h0000, count_ext, 5'b00000, overflow, empty, full};
        OFS_CYCLE:  mmio_rdata = cycle;
        default:    mmio_rdata = {31'b0, halt};
      endcase
    end
  end

`ifdef MMIO_CONSOLE_PRINT_EN
  logic       halt_q;
  logic       fin_armed;
  logic [1:0] fin_cnt;

  // Echo drained bytes; on halt report the cycle count and end two cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_q    <= 1'b0;
      fin_armed <= 1'b0;
      fin_cnt   <= 2'd0;
    end else begin
      halt_q <= halt;
      if (pop) begin
        $write("%c", tx_data);
      end
      if (halt && !halt_q) begin
        $display("mmio_console: halt at cycle %0d", cycle);
        fin_armed <= 1'b1;
        fin_cnt   <= 2'd0;
      end else if (fin_armed) begin
        if (fin_cnt == 2'd1) begin
          $finish;
        end
        fin_cnt <= fin_cnt + 2'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmio_console.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_console
// Description : Self-checking bench for mmio_console: a table of per-cycle
//               bus vectors plus hand-written overflow, wrap, halt and
//               reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_console;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic        mmio_hit;
  logic [31:0] mmio_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt;

  int checks   = 0;
  int failures = 0;

  // Reference cycle counter / halt flag.
  logic [31:0] m_cyc;
  logic        m_halt;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        rdy;
    logic        e_hit;
    logic [31:0] e_rdata;
    logic        e_valid;
    logic [7:0]  e_data;
  } vec_t;

  vec_t vecs[$];

  mmio_console #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_addr      (mem_addr),
    .mem_write_en  (mem_write_en),
    .mem_write_data(mem_write_data),
    .mmio_hit      (mmio_hit),
    .mmio_rdata    (mmio_rdata),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .halt          (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the cycle counter and halt flag.
  always @(posedge clk) begin
    if (reset) begin
      m_cyc  = 32'd0;
      m_halt = 1'b0;
    end else begin
      if (!m_halt) m_cyc = m_cyc + 32'd1;
      if (mem_write_en && (mem_addr[31:2] == ((BASE + 32'hC) >> 2)) && mem_write_data[0])
        m_halt = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d, input logic r);
    mem_addr       = a;
    mem_write_en   = we;
    mem_write_data = d;
    tx_ready       = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic [31:0] a, input logic we, input logic [31:0] d, input logic r,
                     input logic eh, input logic [31:0] er, input logic ev, input logic [7:0] ed);
    vec_t v;
    v.addr = a; v.we = we; v.wdata = d; v.rdy = r;
    v.e_hit = eh; v.e_rdata = er; v.e_valid = ev; v.e_data = ed;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Pre-edge expectations for each cycle of the table.
    add(BASE + 32'h4, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0000_0002, 1'b0, 8'h00);
    add(BASE + 32'h0, 1'b1, 32'h48, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 8'h00);
    add(BASE + 32'h0, 1'b1, 32'h69, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 8'h48);
    add(BASE + 32'h4, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0000_0200, 1'b1, 8'h48);
    add(BASE + 32'h4, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0000_0200, 1'b1, 8'h48);
    add(BASE + 32'h4, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0000_0100, 1'b1, 8'h69);
    add(BASE + 32'h4, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0000_0002, 1'b0, 8'h00);
    add(32'h0000_0010, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 8'h00);
    add(32'h0000_0010, 1'b1, 32'h55, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 8'h00);
    add(32'hFFFF_FFF5, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0000_0002, 1'b0, 8'h00);
    add(BASE + 32'hC, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0000_0000, 1'b0, 8'h00);
    add(BASE + 32'hC, 1'b1, 32'h2,  1'b0, 1'b1, 32'h0000_0000, 1'b0, 8'h00);
    add(BASE + 32'hC, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0000_0000, 1'b0, 8'h00);
    add(BASE + 32'h8, 1'b1, 32'hDEAD, 1'b0, 1'b1, 32'hxxxx_xxxx, 1'b0, 8'h00);
    add(BASE + 32'h0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0000_0000, 1'b0, 8'h00);

    reset = 1'b1;
    drive(32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state and cycle counter ten cycles after reset release.
    drive(BASE + 32'h4, 1'b0, 32'h0, 1'b0);
    chk("reset_status", mmio_rdata, 32'h0000_0002);
    chk("reset_halt", {31'b0, halt}, 32'h0);
    chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    drive(BASE + 32'h8, 1'b0, 32'h0, 1'b0);
    chk("cycle_after_10", mmio_rdata, 32'd10);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].rdy);
      chk($sformatf("vec%0d_hit", i), {31'b0, mmio_hit}, {31'b0, vecs[i].e_hit});
      if (vecs[i].addr[3:2] == 2'd2 && vecs[i].e_hit)
        chk($sformatf("vec%0d_cycle", i), mmio_rdata, m_cyc);
      else
        chk($sformatf("vec%0d_rdata", i), mmio_rdata, vecs[i].e_rdata);
      chk($sformatf("vec%0d_valid", i), {31'b0, tx_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("vec%0d_data", i), {24'b0, tx_data}, {24'b0, vecs[i].e_data});
      tick();
    end

    // Overflow: nine pushes into an eight-entry FIFO.
    for (int i = 0; i < 9; i++) begin
      drive(BASE, 1'b1, 32'h10 + i, 1'b0);
      tick();
    end
    drive(BASE + 32'h4, 1'b0, 32'h0, 1'b0);
    chk("status_overflow", mmio_rdata, 32'h0000_0805);
    tick();
    drive(BASE + 32'h4, 1'b1, 32'h4, 1'b0);
    tick();
    drive(BASE + 32'h4, 1'b0, 32'h0, 1'b0);
    chk("status_ovf_cleared", mmio_rdata, 32'h0000_0801);

    // Push while full with a simultaneous pop.
    drive(BASE, 1'b1, 32'hAA, 1'b1);
    chk("full_pushpop_head", {24'b0, tx_data}, 32'h10);
    tick();
    drive(BASE + 32'h4, 1'b0, 32'h0, 1'b0);
    chk("status_after_pushpop", mmio_rdata, 32'h0000_0801);

    // Drain: bytes 0x11..0x17, then the wrapped 0xAA.
    for (int i = 0; i < 8; i++) begin
      drive(BASE + 32'h4, 1'b0, 32'h0, 1'b1);
      chk($sformatf("drain%0d_valid", i), {31'b0, tx_valid}, 32'h1);
      chk($sformatf("drain%0d_data", i), {24'b0, tx_data}, (i < 7) ? (32'h11 + i) : 32'hAA);
      tick();
    end
    drive(BASE + 32'h4, 1'b0, 32'h0, 1'b0);
    chk("drained_valid", {31'b0, tx_valid}, 32'h0);
    chk("drained_status", mmio_rdata, 32'h0000_0002);

    // Halt: sticky, freezes the cycle counter, FIFO keeps working.
    drive(BASE + 32'hC, 1'b1, 32'h1, 1'b0);
    tick();
    drive(BASE + 32'h8, 1'b0, 32'h0, 1'b0);
    chk("halt_set", {31'b0, halt}, 32'h1);
    chk("halt_cycle", mmio_rdata, m_cyc);
    repeat (20) tick();
    chk("halt_cycle_frozen", mmio_rdata, m_cyc);
    drive(BASE + 32'hC, 1'b1, 32'h0, 1'b0);
    tick();
    drive(BASE + 32'hC, 1'b0, 32'h0, 1'b0);
    chk("halt_sticky", mmio_rdata, 32'h1);
    drive(BASE, 1'b1, 32'h77, 1'b0);
    tick();
    drive(BASE + 32'h4, 1'b0, 32'h0, 1'b1);
    chk("halted_push_valid", {31'b0, tx_valid}, 32'h1);
    chk("halted_push_data", {24'b0, tx_data}, 32'h77);
    tick();
    drive(BASE + 32'h4, 1'b0, 32'h0, 1'b0);
    chk("halted_drain_status", mmio_rdata, 32'h0000_0002);

    // Reset with three bytes queued and the sink ready.
    for (int i = 0; i < 3; i++) begin
      drive(BASE, 1'b1, 32'h30 + i, 1'b0);
      tick();
    end
    reset = 1'b1;
    drive(BASE + 32'h4, 1'b0, 32'h0, 1'b1);
    tick();
    reset = 1'b0;
    drive(BASE + 32'h4, 1'b0, 32'h0, 1'b1);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
    chk("rst_status", mmio_rdata, 32'h0000_0002);
    chk("rst_halt", {31'b0, halt}, 32'h0);
    drive(BASE + 32'h8, 1'b0, 32'h0, 1'b1);
    chk("rst_cycle", mmio_rdata, 32'h0);
    drive(32'h0000_0010, 1'b0, 32'h0, 1'b0);
    chk("miss_hit", {31'b0, mmio_hit}, 32'h0);
    chk("miss_rdata", mmio_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_console.md
Name: mmio_console

Overview:
- Memory-mapped responder on the core's data-memory bus: `mem_addr`, `mem_write_en`, `mem_write_data` come in; read data goes back out.
- Sits beside `memory`. Top level muxes `mem_data` from this block whenever `mmio_hit` is high.
- Buffers bytes stored by the program in a TX FIFO and drains them over a valid/ready byte stream.
- Also provides a free-running cycle counter and a sticky halt flag that ends simulation runs.

Parameters:
- BASE_ADDR, 32'hFFFF_FFF0, base of the 16-byte register window; must be 16-byte aligned.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..128.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_addr  input  32  byte address from the core.
- mem_write_en  input  1  store strobe from the core.
- mem_write_data  input  32  store data from the core.
- mmio_hit  output  1  high when `mem_addr[31:4] == BASE_ADDR[31:4]`; combinational.
- mmio_rdata  output  32  read data for the addressed register; combinational.
- tx_data  output  8  byte at the FIFO head.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  sink accepts `tx_data` when `tx_valid && tx_ready` at a rising edge.
- halt  output  1  sticky halt request.

Behaviour:
- Register map, offset = `mem_addr[3:2]`; `mem_addr[1:0]` ignored:
  - 0x0 TXDATA: write pushes `mem_write_data[7:0]`; read returns 0.
  - 0x4 STATUS: read gives bit0 full, bit1 empty, bit2 overflow (sticky), bits[15:8] occupancy count zero-extended, other bits 0. Write with bit2=1 clears overflow; other bits are ignored.
  - 0x8 CYCLE: read gives the 32-bit cycle counter; writes ignored.
  - 0xC HALT: write with bit0=1 sets halt; bit0=0 has no effect; read gives {31'b0, halt}.
- Writes take effect only when `mem_write_en && mmio_hit` at a rising edge. When `mmio_hit` is 0, `mmio_rdata` is 0 and writes are ignored.
- Read latency 0: `mmio_rdata` reflects the current registered state for the current `mem_addr`.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits and a count of log2(FIFO_DEPTH)+1 bits. Pointers wrap from FIFO_DEPTH-1 to 0.
  - `tx_valid` = (count != 0). `tx_data` = entry at the read pointer, registered storage (not combinational from the bus).
  - Pop on `tx_valid && tx_ready`; push on a TXDATA write.
  - Push and pop in the same cycle: both occur and count is unchanged; this includes the full case.
  - Push while full with no pop: byte dropped, overflow set, count unchanged.
  - Push while empty: `tx_valid` rises the following cycle. No same-cycle bypass.
- Cycle counter: increments by 1 every cycle while halt=0 and freezes while halt=1. Wraps 0xFFFF_FFFF→0.
- halt: set by a HALT write and cleared only by reset. Once halted, the FIFO continues to accept pushes and drain.
- Reset (synchronous, also mid-transfer or mid-drain):
  - Pointers, count, overflow, cycle counter and halt all go to 0.
  - `tx_valid`=0 and `tx_data`=0.
  - Queued bytes are discarded.
  - Storage contents are don't-care but never visible.
- STATUS read in the same cycle as a push or pop shows the pre-edge state.

Optional Feature:
- Macro: MMIO_CONSOLE_PRINT_EN.
- Defined: on every accepted pop, a simulation-only `$write("%c", tx_data)` echoes the byte. On the rising edge of halt, `$display` prints the cycle counter value and `$finish` is called after 2 further cycles, so in-flight pops complete.
- Undefined: no system tasks; pure synthesizable logic with identical port behaviour.

Test Plan:
- Reset, then read 0x4 → STATUS = 0x0000_0002 (empty). Read 0x8 after 10 cycles → 10, ±0 relative to reset deassert edge.
- `tx_ready`=0; write 0x48, 0x69 to BASE+0 → STATUS count=2, bit1=0. Raise `tx_ready` → `tx_data` 0x48 then 0x69 on consecutive cycles, then `tx_valid`=0.
- `tx_ready`=0; 9 pushes with FIFO_DEPTH=8 → STATUS = 0x0000_0805 (count 8, full, overflow). Write 0x4 to BASE+4 → overflow clears. Drain yields the first 8 bytes only.
- FIFO full, push 0xAA with `tx_ready`=1 in the same cycle → head pops, 0xAA accepted, count stays 8, no overflow. The 0xAA byte exits last, confirming pointer wrap.
- Write 1 to BASE+C at cycle N → halt=1 next cycle. CYCLE read stays constant for 20 cycles. Write 0 to BASE+C → halt stays 1.
- Assert reset with 3 bytes queued and `tx_ready`=1 → next cycle `tx_valid`=0, STATUS=0x2, halt=0, CYCLE=0. A read of address 0x0000_0010 gives `mmio_hit`=0 and `mmio_rdata`=0.
